display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Sequencing controller for the 4-digit multiplexed 7-segment path.
- Converts a 9-bit binary value to BCD sequentially (shift-add-3) under a load/busy/done handshake.
- Holds the result in a display register that updates atomically.
- Time-multiplexes the digits onto the shared BCD/anode bus that feeds the BCD-to-7-segment decoder. This replaces the free-running divider-plus-converter pair.

Parameters:
- IN_W, 9: binary input width; conversion takes exactly IN_W shift cycles.
- DIGITS, 4: number of display digits / anodes.
- DIV_COUNT, 12500: CLK_50 cycles per scan slot (50 MHz / 12500 = 4 kHz slot rate, 1 kHz per digit).

Ports:
- CLK_50, input, 1: system clock, 50 MHz, rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- in, input, IN_W: binary value to display; sampled on an accepted load.
- load, input, 1: conversion request; level-sampled each cycle.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the display register updates.
- BCD, output, 4: BCD digit currently scanned.
- an_i, output, DIGITS: active-low one-hot anode select.

Behaviour:
- Reset values (asynchronous on RST_N=0):
  - prescaler=0, scan index=0, FSM=IDLE
  - scratch and display register all zero
  - busy=0, done=0, BCD=4'd0, an_i=4'b1110
- Prescaler:
  - Counts 0..DIV_COUNT-1 and wraps.
  - tick=1 for the single cycle in which the count equals DIV_COUNT-1.
- Scan:
  - The index advances on tick (0→1→2→3→0).
  - Index 0 is the units digit: an_i=1110. Index 1: 1101. Index 2: 1011. Index 3 (thousands): 0111.
  - BCD and an_i are registered and change on the same edge as the index, so they are never skewed.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: when load=1, capture `in` into the shift register, clear the BCD scratch, set counter=IN_W, go to SHIFT. busy rises on the next edge.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, bin} left by 1 and decrement the counter. Leave for DONE when the counter reaches 1 on that cycle, giving exactly IN_W shifts.
  - DONE: copy scratch to the display register, done=1 for one cycle, busy=0, go to IDLE.
  - Latency: load sampled at edge 0 → done high and display updated IN_W+1 cycles later (10 for IN_W=9).
- load while busy (SHIFT or DONE) is ignored, not queued.
- load held high in IDLE re-triggers a conversion on the cycle after DONE.
- Scratch width is 4·DIGITS bits. The maximum input (511) fits, so there is no overflow. Digit 3 reads 0 for IN_W=9.
- The scan reads only the display register. A running conversion never disturbs the digits shown.
- A simultaneous tick and done on the same edge shows the new value from that edge.
- Reset mid-conversion aborts it: no done pulse, and the display returns to 0000.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit above the most significant non-zero digit is blanked: its an_i bit is held at 1 during its slot, and BCD still shows the digit value.
  - Units (index 0) is never blanked, so 0 displays as a single "0".
  - The blank mask is computed from the display register and registered with the scan.
- Undefined: all DIGITS digits are always lit, including leading zeros.

Decomposition:
- Shared package/header display_defs holds:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the DIGITS default
  - the anode one-hot patterns for index 0-3 and AN_OFF=4'b1111
- Natural sub-module: bin2bcd_seq, the shift-add-3 engine, with ports load/busy/done/bin/bcd_out.
- Prescaler, scan counter and anode mux stay in display_scan_ctrl.

Test Plan:
- Reset → with RST_N low: an_i=1110, BCD=0, busy=0, done=0. Assert and release RST_N asynchronously between edges; the outputs change without waiting for a clock edge.
- DIV_COUNT=4, load with in=255:
  - busy=1 next cycle; done pulses 10 cycles after load.
  - Scan then gives (an_i,BCD) = (1110,5), (1101,5), (1011,2), (0111,0), each held for 4 cycles, then wraps.
- Boundary values: in=511 → digits 0,5,1,1. in=0 → 0,0,0,0. in=9 → units 9. Each conversion has exactly one done pulse.
- load in=123, then load in=45 three cycles later → second load ignored, display shows 0123, one done only. With load held high, a second conversion starts right after done.
- RST_N low at cycle 5 of a conversion of in=300 → outputs at reset values, no done pulse. A new load after release converts normally.
- With LEADING_ZERO_BLANK_EN and in=7 → slots 1-3 show an_i=1111, slot 0 shows an_i=1110 and BCD=7. With in=0, slot 0 shows BCD=0.

Source files
------------

// File: rtl/display_defs_pkg.sv
// Shared constants for the multiplexed 7-segment scan path:
// converter FSM encodings, default digit count and anode patterns.
package display_defs;

  localparam int DIGITS_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [3:0] an_pat(
    input logic [1:0] idx
  );
    logic [3:0] r;
    r = AN_D0;
    unique case (idx)
      2'd0: r = AN_D0;
      2'd1: r = AN_D1;
      2'd2: r = AN_D2;
      2'd3: r = AN_D3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD engine.
// One shift per cycle, IN_W shifts per conversion.
module bin2bcd_seq
  import display_defs::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IN_W-1:0]  bin,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] bcd_out
);

  localparam int CW = $clog2(IN_W + 1);

  logic [1:0]       st_q, st_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [OUT_W-1:0] scr_q, scr_d;
  logic [OUT_W-1:0] adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [OUT_W-1:0] add3(
    input logic [OUT_W-1:0] s
  );
    logic [OUT_W-1:0] r;
    r = s;
    for (int i = 0; i < OUT_W / 4; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj = add3(scr_q);

  always_comb begin
    st_d  = st_q;
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (load) begin
          bin_d = bin;
          scr_d = '0;
          cnt_d = CW'(IN_W);
          st_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          st_d = ST_DONE;
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
    end
  end

  // Result is stable in scr_q for the whole DONE cycle.
  assign busy    = (st_q != ST_IDLE);
  assign done    = (st_q == ST_DONE);
  assign bcd_out = scr_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan controller: sequential BCD conversion,
// atomic display register, digit mux. LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_ctrl
  import display_defs::*;
#(
  parameter int IN_W      = 9,
  parameter int DIGITS    = DIGITS_DEF,
  parameter int DIV_COUNT = 12500
) (
  input  logic              CLK_50,
  input  logic              RST_N,
  input  logic [IN_W-1:0]   in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [3:0]        BCD,
  output logic [DIGITS-1:0] an_i
);

  localparam int PW = $clog2(DIV_COUNT);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 4 * DIGITS;

  logic [PW-1:0]     pre_q, pre_d;
  logic              tick;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic [BW-1:0]     conv_bcd;
  logic              conv_done;
  logic              done_q;
  logic [3:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              blank;

  bin2bcd_seq #(
    .IN_W  (IN_W),
    .OUT_W (BW)
  ) u_conv (
    .clk     (CLK_50),
    .rst_n   (RST_N),
    .load    (load),
    .bin     (in),
    .busy    (busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  assign tick  = (pre_q == PW'(DIV_COUNT - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);
  assign idx_d = tick ? idx_q + IW'(1) : idx_q;

  // Bypass so a slot sampled on the update edge shows the new value.
  assign disp_d = conv_done ? conv_bcd : disp_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (idx_d != '0) && ((disp_d >> (4 * idx_d)) == '0);
`else
  assign blank = 1'b0;
`endif

  assign bcd_d = disp_d[4*idx_d +: 4];
  assign an_d  = blank ? AN_OFF : an_pat(idx_d);

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      done_q <= 1'b0;
      bcd_q  <= 4'd0;
      an_q   <= AN_D0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      done_q <= conv_done;
      bcd_q  <= bcd_d;
      an_q   <= an_d;
    end
  end

  assign done = done_q;
  assign BCD  = bcd_q;
  assign an_i = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a fast scan divider.
// Honours LEADING_ZERO_BLANK_EN when defined.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic       CLK_50 = 1'b0;
  logic       RST_N  = 1'b1;
  logic       load   = 1'b0;
  logic [8:0] in_v   = '0;
  logic       busy;
  logic       done;
  logic [3:0] BCD;
  logic [3:0] an_i;

  int total = 0;
  int bad   = 0;

  logic [15:0] expq[$];
  logic [15:0] mdisp = 16'h0;
  int mcnt = 0;
  int midx = 0;

  int          vin[5]  = '{255, 511, 0, 9, 7};
  logic [15:0] vexp[5] = '{16'h0255, 16'h0511, 16'h0000, 16'h0009, 16'h0007};

  display_scan_ctrl #(
    .IN_W      (9),
    .DIGITS    (4),
    .DIV_COUNT (DIV)
  ) dut (
    .CLK_50 (CLK_50),
    .RST_N  (RST_N),
    .in     (in_v),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .BCD    (BCD),
    .an_i   (an_i)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference scan position.
  always @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      mcnt <= 0;
      midx <= 0;
    end else if (mcnt == DIV - 1) begin
      mcnt <= 0;
      midx <= (midx + 1) % 4;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // Monitor: pops expected display on each done, checks the scan bus every cycle.
  always @(negedge CLK_50) begin
    logic [3:0] ea;
    logic [3:0] ed;
    if (!RST_N) mdisp = 16'h0;
    if (done) begin
      check("done_has_expect", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) mdisp = expq.pop_front();
    end
    ed = mdisp[4*midx +: 4];
    ea = 4'hF ^ (4'h1 << midx);
`ifdef LEADING_ZERO_BLANK_EN
    if (midx > 0 && (mdisp >> (4 * midx)) == 16'h0) ea = 4'hF;
`endif
    check("scan_an", 32'(an_i), 32'(ea));
    check("scan_bcd", 32'(BCD), 32'(ed));
  end

  task automatic do_load(input int v, input logic [15:0] e, input bit push);
    @(negedge CLK_50);
    in_v = 9'(v);
    load = 1'b1;
    if (push) expq.push_back(e);
    @(negedge CLK_50);
    load = 1'b0;
    check("busy_after_load", 32'(busy), 1);
  endtask

  task automatic wait_done(input string nm, input int exp_k);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge CLK_50);
      k++;
    end
    check(nm, k, exp_k);
  endtask

  initial begin
    #1 RST_N = 1'b0;
    #2;
    check("rst_an", 32'(an_i), 32'(4'b1110));
    check("rst_bcd", 32'(BCD), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge CLK_50);
    #3 RST_N = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_load(vin[i], vexp[i], 1'b1);
      wait_done("latency", 10);
      @(negedge CLK_50);
      check("done_one_cycle", 32'(done), 0);
      check("busy_after_done", 32'(busy), 0);
      repeat (18) @(negedge CLK_50);
    end

    // Load while busy is dropped.
    do_load(123, 16'h0123, 1'b1);
    repeat (2) @(negedge CLK_50);
    in_v = 9'd45;
    load = 1'b1;
    @(negedge CLK_50);
    load = 1'b0;
    wait_done("latency_ignored", 7);
    repeat (24) @(negedge CLK_50);

    // Held load re-triggers right after done.
    @(negedge CLK_50);
    in_v = 9'd42;
    load = 1'b1;
    expq.push_back(16'h0042);
    @(negedge CLK_50);
    wait_done("latency_hold1", 10);
    in_v = 9'd77;
    expq.push_back(16'h0077);
    @(negedge CLK_50);
    check("retrigger_busy", 32'(busy), 1);
    load = 1'b0;
    wait_done("latency_hold2", 10);
    repeat (18) @(negedge CLK_50);

    // Reset mid-conversion aborts it.
    do_load(300, 16'h0, 1'b0);
    repeat (4) @(negedge CLK_50);
    #3 RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_an", 32'(an_i), 32'(4'b1110));
    check("abort_bcd", 32'(BCD), 0);
    repeat (2) @(negedge CLK_50);
    #3 RST_N = 1'b1;
    repeat (16) @(negedge CLK_50);
    do_load(300, 16'h0300, 1'b1);
    wait_done("latency_after_abort", 10);
    repeat (18) @(negedge CLK_50);

    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
